// File: rtl/float_type.sv
// rtl/float_type.sv - FP32 status enum, constants and divider-local types
package float_type;

    typedef enum logic [2:0] {
        VALID,
        OVERFLOW,
        UNDERFLOW,
        NaN,
        positive_infinity,
        negative_infinity
    } type_of_float;

    localparam int          FP32_BIAS    = 127;
    localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  FP32_INF_EXP = 8'hFF;

    // Special-case outcome decided at acceptance; SP_NONE means a real divide is needed
    typedef enum logic [1:0] {
        SP_NONE,
        SP_NAN,
        SP_INF,
        SP_ZERO
    } div_special_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVIDE,
        S_PACK,
        S_DONE
    } div_state_t;

endpackage

// File: rtl/fp32_div_round_pack.sv
// rtl/fp32_div_round_pack.sv - normalise, round-to-nearest-even, range check and pack
module fp32_div_round_pack
    import float_type::*;
(
    input  logic [25:0]       q,
    input  logic              rem_nz,
    input  logic              sign,
    input  logic signed [9:0] exp_in,
    output logic [31:0]       result,
    output type_of_float      result_str
);

    logic [22:0]       mant;
    logic              guard;
    logic              sticky;
    logic              inc;
    logic [23:0]       mant_sum;
    logic [22:0]       mant_r;
    logic signed [9:0] exp_n;
    logic signed [9:0] exp_r;

    // The quotient of two [1,2) significands is in (0.5,2): either q[25] or q[24] leads
    always_comb begin
        if (q[25]) begin
            mant   = q[24:2];
            guard  = q[1];
            sticky = q[0] | rem_nz;
            exp_n  = exp_in;
        end else begin
            mant   = q[23:1];
            guard  = q[0];
            sticky = rem_nz;
            exp_n  = exp_in - 10'sd1;
        end

        inc      = guard & (sticky | mant[0]);
        mant_sum = {1'b0, mant} + {23'd0, inc};

        if (mant_sum[23]) begin
            mant_r = 23'd0;
            exp_r  = exp_n + 10'sd1;
        end else begin
            mant_r = mant_sum[22:0];
            exp_r  = exp_n;
        end

        if (exp_r >= 10'sd255) begin
            result     = {sign, FP32_INF_EXP, 23'd0};
            result_str = OVERFLOW;
        end else if (exp_r <= 10'sd0) begin
            result     = {sign, 31'd0};
            result_str = UNDERFLOW;
        end else begin
            result     = {sign, exp_r[7:0], mant_r};
            result_str = VALID;
        end
    end

endmodule

// File: rtl/if_normal.sv
// rtl/if_normal.sv - combinational FP32 operand classifier with denormal flush
module if_normal
    import float_type::*;
(
    input  logic [31:0] x,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan
);

    logic [7:0]  exp_f;
    logic [22:0] frac_f;

    assign exp_f  = x[30:23];
    assign frac_f = x[22:0];

    // Denormals (exp==0) count as zero regardless of the fraction bits
    always_comb begin
        is_zero = (exp_f == 8'd0);
        is_inf  = (exp_f == FP32_INF_EXP) && (frac_f == 23'd0);
        is_nan  = (exp_f == FP32_INF_EXP) && (frac_f != 23'd0);
    end

endmodule

// File: rtl/fp32_div_seq.sv
// rtl/fp32_div_seq.sv - iterative FP32 divider, restoring radix-2, one quotient bit per cycle
module fp32_div_seq
    import float_type::*;
#(
    parameter int          QBITS     = 26,
    parameter logic [31:0] NAN_VALUE = 32'h7FC0_0000
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [31:0]  a,
    input  logic [31:0]  b,
    output logic [31:0]  result,
    output type_of_float result_str,
    output logic         done,
    output logic         busy
);

    div_state_t        state;
    div_state_t        state_next;
    div_special_t      special_c;
    div_special_t      special_q;
    logic              sign_q;
    logic signed [9:0] exp_q;
    logic [24:0]       rem;
    logic [23:0]       mb;
    logic [QBITS-1:0]  quo;
    logic [4:0]        count;
    logic              accept;

    logic              a_zero, a_inf, a_nan;
    logic              b_zero, b_inf, b_nan;
    logic [31:0]       rp_result;
    type_of_float      rp_str;

    if_normal u_cls_a (
        .x       (a),
        .is_zero (a_zero),
        .is_inf  (a_inf),
        .is_nan  (a_nan)
    );

    if_normal u_cls_b (
        .x       (b),
        .is_zero (b_zero),
        .is_inf  (b_inf),
        .is_nan  (b_nan)
    );

    fp32_div_round_pack u_round_pack (
        .q          (quo),
        .rem_nz     (rem != 25'd0),
        .sign       (sign_q),
        .exp_in     (exp_q),
        .result     (rp_result),
        .result_str (rp_str)
    );

    assign accept = (state == S_IDLE) && start;

    // Special-case priority: NaN-producing first, then infinity, then exact zero
    always_comb begin
        special_c = SP_NONE;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            special_c = SP_NAN;
        end else if (a_inf || b_zero) begin
            special_c = SP_INF;
        end else if (a_zero || b_inf) begin
            special_c = SP_ZERO;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and busy; special cases skip the divide loop entirely
    always_comb begin
        state_next = state;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (special_c != SP_NONE) ? S_PACK : S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                if (count == 5'(QBITS - 1)) begin
                    state_next = S_PACK;
                end
            end
            S_PACK:  state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Operand capture, restoring divide step, result register and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            special_q  <= SP_NONE;
            sign_q     <= 1'b0;
            exp_q      <= 10'sd0;
            rem        <= 25'd0;
            mb         <= 24'd0;
            quo        <= '0;
            count      <= 5'd0;
            result     <= 32'd0;
            result_str <= VALID;
            done       <= 1'b0;
        end else begin
            done <= (state == S_DONE);
            if (accept) begin
                special_q <= special_c;
                sign_q    <= a[31] ^ b[31];
                exp_q     <= $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]})
                             + 10'(FP32_BIAS);
                rem       <= {2'b01, a[22:0]};
                mb        <= {1'b1, b[22:0]};
                quo       <= '0;
                count     <= 5'd0;
            end else if (state == S_DIVIDE) begin
                // Remainder stays below 2*mb, so the left shift never loses a set bit
                if (rem >= {1'b0, mb}) begin
                    quo <= {quo[QBITS-2:0], 1'b1};
                    rem <= (rem - {1'b0, mb}) << 1;
                end else begin
                    quo <= {quo[QBITS-2:0], 1'b0};
                    rem <= rem << 1;
                end
                count <= count + 5'd1;
            end else if (state == S_PACK) begin
                case (special_q)
                    SP_NAN: begin
                        result     <= NAN_VALUE;
                        result_str <= NaN;
                    end
                    SP_INF: begin
                        result     <= {sign_q, FP32_INF_EXP, 23'd0};
                        result_str <= sign_q ? negative_infinity : positive_infinity;
                    end
                    SP_ZERO: begin
                        result     <= {sign_q, 31'd0};
                        result_str <= VALID;
                    end
                    default: begin
                        result     <= rp_result;
                        result_str <= rp_str;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fp32_div_seq.sv
// tb/tb_fp32_div_seq.sv - scoreboard testbench for fp32_div_seq
module tb_fp32_div_seq;
    import float_type::*;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [31:0]  a;
    logic [31:0]  b;
    logic [31:0]  result;
    type_of_float result_str;
    logic         done;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0]  res;
        type_of_float str;
        int           lat;
        string        name;
    } exp_t;

    exp_t sb[$];

    localparam int LAT_DIV = 28;
    localparam int LAT_SP  = 2;

    fp32_div_seq #(
        .QBITS     (26),
        .NAN_VALUE (32'h7FC0_0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .result     (result),
        .result_str (result_str),
        .done       (done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                          input logic [31:0] eres, input type_of_float estr,
                          input int elat, input string name);
        exp_t e;
        exp_t got;
        int   cyc;
        bit   seen;
        e.res  = eres;
        e.str  = estr;
        e.lat  = elat;
        e.name = name;
        sb.push_back(e);
        @(negedge clk);
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
        seen  = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done === 1'b1) seen = 1'b1;
        end
        got = sb.pop_front();
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_timeout: no done within %0d cycles, required done", got.name, cyc);
        end else begin
            checks++;
            if (result !== got.res) begin
                failures++;
                $display("FAIL %s_result: got %h required %h", got.name, result, got.res);
            end
            checks++;
            if (result_str !== got.str) begin
                failures++;
                $display("FAIL %s_str: got %0d required %0d", got.name, result_str, got.str);
            end
            if (cyc !== got.lat) begin
                failures++;
                $display("FAIL %s_latency: got %0d required %0d", got.name, cyc, got.lat);
            end
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL %s_busy_at_done: got %b required 0", got.name, busy);
            end
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL %s_done_pulse: got %b required 0", got.name, done);
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if (result !== 32'd0) begin
            failures++;
            $display("FAIL reset_result: got %h required 00000000", result);
        end
        checks++;
        if (result_str !== VALID) begin
            failures++;
            $display("FAIL reset_str: got %0d required %0d", result_str, VALID);
        end
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done: got %b required 0", done);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_divide();
        run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, VALID, LAT_DIV, "six_by_two");
        run_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, VALID, LAT_DIV, "one_third");
        run_op(32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, VALID, LAT_DIV, "neg_six_by_two");
        run_op(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, VALID, LAT_DIV, "one_by_one");
    endtask

    task automatic test_infinity();
        run_op(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, positive_infinity, LAT_SP, "one_by_zero");
        run_op(32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, negative_infinity, LAT_SP, "neg_one_by_zero");
        run_op(32'h3F80_0000, 32'h0000_0001, 32'h7F80_0000, positive_infinity, LAT_SP, "one_by_denorm");
    endtask

    task automatic test_zero();
        run_op(32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, VALID, LAT_SP, "zero_by_one");
        run_op(32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000, VALID, LAT_SP, "one_by_neg_inf");
        run_op(32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, VALID, LAT_SP, "denorm_by_one");
    endtask

    task automatic test_range();
        run_op(32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, OVERFLOW,  LAT_DIV, "overflow");
        run_op(32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, UNDERFLOW, LAT_DIV, "underflow");
    endtask

    task automatic test_nan();
        run_op(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, NaN, LAT_SP, "nan_operand");
        run_op(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, NaN, LAT_SP, "zero_by_zero");
        run_op(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, NaN, LAT_SP, "inf_by_inf");
    endtask

    task automatic test_abort();
        int  spurious;
        @(negedge clk);
        a     = 32'h40C0_0000;
        b     = 32'h4000_0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (result !== 32'd0) begin
            failures++;
            $display("FAIL abort_result: got %h required 00000000", result);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_busy: got %b required 0", busy);
        end
        checks++;
        if (result_str !== VALID) begin
            failures++;
            $display("FAIL abort_str: got %0d required %0d", result_str, VALID);
        end
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            failures++;
            $display("FAIL abort_no_done: got %0d pulses required 0", spurious);
        end
        // Reset and start on the same edge: reset must win
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_beats_start: busy got %b required 0", busy);
        end
    endtask

    task automatic test_busy_ignore();
        exp_t e;
        exp_t got;
        int   cyc;
        bit   seen;
        int   spurious;
        e.res  = 32'h4040_0000;
        e.str  = VALID;
        e.lat  = LAT_DIV;
        e.name = "busy_ignore";
        sb.push_back(e);
        @(negedge clk);
        a     = 32'h40C0_0000;
        b     = 32'h4000_0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
        seen  = 1'b0;
        // Hold a conflicting special-case request high from mid-divide through the DONE state
        while (!seen && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 3) begin
                a     = 32'h3F80_0000;
                b     = 32'h0000_0000;
                start = 1'b1;
            end
            if (cyc == 10) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL busy_mid_divide: got %b required 1", busy);
                end
            end
            if (done === 1'b1) seen = 1'b1;
        end
        start = 1'b0;
        got = sb.pop_front();
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_timeout: no done within %0d cycles, required done", got.name, cyc);
        end else begin
            checks++;
            if (result !== got.res || result_str !== got.str) begin
                failures++;
                $display("FAIL %s_result: got %h/%0d required %h/%0d",
                         got.name, result, result_str, got.res, got.str);
            end
            if (cyc !== got.lat) begin
                failures++;
                $display("FAIL %s_latency: got %0d required %0d", got.name, cyc, got.lat);
            end
        end
        spurious = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            failures++;
            $display("FAIL busy_not_queued: got %0d extra done required 0", spurious);
        end
    endtask

    task automatic test_back_to_back();
        run_op(32'h4120_0000, 32'h4080_0000, 32'h4020_0000, VALID, LAT_DIV, "ten_by_four");
        run_op(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, positive_infinity, LAT_SP, "b2b_inf");
        run_op(32'h4000_0000, 32'hC080_0000, 32'hBF00_0000, VALID, LAT_DIV, "two_by_neg_four");
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_divide();
        test_infinity();
        test_zero();
        test_range();
        test_nan();
        test_abort();
        test_busy_ignore();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
